// File: rtl/memory_bus_defs.sv
// Shared memory-bus vocabulary: access sizes, operations and the copy-engine state encoding.
package memory_bus_defs;

  localparam logic [1:0] MEMORY_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEMORY_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEMORY_SIZE_WORD = 2'd2;

  localparam logic MEMORY_OPERATION_READ  = 1'b0;
  localparam logic MEMORY_OPERATION_WRITE = 1'b1;

  typedef enum logic [2:0] {
    STATE_IDLE,
    STATE_SELECT,
    STATE_READ_REQUEST,
    STATE_READ_RELEASE,
    STATE_WRITE_REQUEST,
    STATE_WRITE_RELEASE,
    STATE_FINISH
  } copy_state_t;

  // Bits of the data bus that carry payload for a given access size.
  function automatic logic [31:0] size_mask(input logic [1:0] size);
    case (size)
      MEMORY_SIZE_BYTE: size_mask = 32'h0000_00FF;
      MEMORY_SIZE_HALF: size_mask = 32'h0000_FFFF;
      default:          size_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      MEMORY_SIZE_BYTE: size_bytes = 3'd1;
      MEMORY_SIZE_HALF: size_bytes = 3'd2;
      default:          size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memory_chunk_select.sv
// Picks the largest legal access for the next chunk from both alignments and the bytes left.
module memory_chunk_select
  import memory_bus_defs::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter bit ALLOW_WORD    = 1'b1
) (
  input  logic [1:0]               source_alignment,
  input  logic [1:0]               destination_alignment,
  input  logic [ADDRESS_WIDTH-1:0] remaining,
  output logic [1:0]               size,
  output logic [2:0]               byte_count
);

  always_comb begin
    // NOTE: assign a default before any branch so every path drives size and no latch is inferred.
    size = MEMORY_SIZE_BYTE;
    if (ALLOW_WORD && source_alignment == 2'b00 && destination_alignment == 2'b00
        && remaining >= ADDRESS_WIDTH'(4)) begin
      size = MEMORY_SIZE_WORD;
    end else if (!source_alignment[0] && !destination_alignment[0]
                 && remaining >= ADDRESS_WIDTH'(2)) begin
      size = MEMORY_SIZE_HALF;
    end
    byte_count = size_bytes(size);
  end

endmodule

// File: rtl/memory_copy_initiator.sv
// Bus-master block copier: one read then one write per chunk over a four-phase enable/ready handshake.
module memory_copy_initiator
  import memory_bus_defs::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter bit ALLOW_WORD    = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] source_address,
  input  logic [ADDRESS_WIDTH-1:0] destination_address,
  input  logic [31:0]              length,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] memory_address,
  input  logic [31:0]              memory_data_in,
  output logic [31:0]              memory_data_out,
  output logic [1:0]               memory_data_size,
  output logic                     memory_enable,
  output logic                     memory_operation,
  input  logic                     memory_ready
);

  copy_state_t              state;
  logic [ADDRESS_WIDTH-1:0] source;
  logic [ADDRESS_WIDTH-1:0] destination;
  logic [ADDRESS_WIDTH-1:0] remaining;
  logic [ADDRESS_WIDTH-1:0] remaining_next;
  logic [2:0]               chunk_bytes;
  logic [31:0]              read_data;
  logic [1:0]               select_size;
  logic [2:0]               select_bytes;

  memory_chunk_select #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .ALLOW_WORD   (ALLOW_WORD)
  ) u_chunk_select (
    .source_alignment     (source[1:0]),
    .destination_alignment(destination[1:0]),
    .remaining            (remaining),
    .size                 (select_size),
    .byte_count           (select_bytes)
  );

  assign remaining_next = remaining - ADDRESS_WIDTH'(chunk_bytes);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= STATE_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      memory_address   <= '0;
      memory_data_out  <= '0;
      memory_data_size <= MEMORY_SIZE_BYTE;
      memory_enable    <= 1'b0;
      memory_operation <= MEMORY_OPERATION_READ;
      source           <= '0;
      destination      <= '0;
      remaining        <= '0;
      chunk_bytes      <= '0;
      read_data        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values, order-independent.
      done <= 1'b0;
      case (state)
        STATE_IDLE: begin
          if (start) begin
            source      <= source_address;
            destination <= destination_address;
            remaining   <= ADDRESS_WIDTH'(length);
            busy        <= 1'b1;
            state       <= (length == 32'd0) ? STATE_FINISH : STATE_SELECT;
          end
        end
        STATE_SELECT: begin
          memory_address   <= source;
          memory_data_size <= select_size;
          memory_operation <= MEMORY_OPERATION_READ;
          memory_enable    <= 1'b1;
          chunk_bytes      <= select_bytes;
          state            <= STATE_READ_REQUEST;
        end
        STATE_READ_REQUEST: begin
          if (memory_ready) begin
            read_data     <= memory_data_in & size_mask(memory_data_size);
            memory_enable <= 1'b0;
            state         <= STATE_READ_RELEASE;
          end
        end
        STATE_READ_RELEASE: begin
          // Wait for the responder to release ready before opening the write phase.
          if (!memory_ready) begin
            memory_address   <= destination;
            memory_operation <= MEMORY_OPERATION_WRITE;
            memory_data_out  <= read_data;
            memory_enable    <= 1'b1;
            state            <= STATE_WRITE_REQUEST;
          end
        end
        STATE_WRITE_REQUEST: begin
          if (memory_ready) begin
            memory_enable <= 1'b0;
            state         <= STATE_WRITE_RELEASE;
          end
        end
        STATE_WRITE_RELEASE: begin
          if (!memory_ready) begin
            source      <= source + ADDRESS_WIDTH'(chunk_bytes);
            destination <= destination + ADDRESS_WIDTH'(chunk_bytes);
            remaining   <= remaining_next;
            state       <= (remaining_next == '0) ? STATE_FINISH : STATE_SELECT;
          end
        end
        STATE_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= STATE_IDLE;
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: doc/memory_copy_initiator.md
Name: memory_copy_initiator

Overview:
- Synthesizable bus master that drives the CPU memory interface from the initiator side.
- Copies a block of bytes from a source address to a destination address using four-phase enable/ready transactions.
- Each chunk is one read followed by one write. The largest legal access size is chosen per chunk.
- Sits beside the CPU as a second initiator for DMA-style loads of RAM. Bus arbitration is external and out of scope.

Parameters:
- ADDRESS_WIDTH, 32, width of memory_address and of the internal source, destination and remaining counters.
- ALLOW_WORD, 1, when 0 the word size (2) is never issued; only half and byte accesses are used.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request; sampled only in IDLE
- source_address  input  ADDRESS_WIDTH  first byte to read; latched on accepted start
- destination_address  input  ADDRESS_WIDTH  first byte to write; latched on accepted start
- length  input  32  byte count; latched on accepted start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the copy completes
- memory_address  output  ADDRESS_WIDTH  transaction address
- memory_data_in  input  32  read data from responder; byte in [7:0], half in [15:0]
- memory_data_out  output  32  write data; unused upper bits driven 0
- memory_data_size  output  2  0 = byte, 1 = half, 2 = word; 3 is never driven
- memory_enable  output  1  transaction request
- memory_operation  output  1  0 = read, 1 = write
- memory_ready  input  1  responder completion, synchronous to clock

Behaviour:
- Interface: one clock, `clock`. Reset is asynchronous and active-low, `reset_n`.
- All outputs are registered.
- Reset: state IDLE; busy, done, memory_enable and memory_operation are 0; memory_address, memory_data_out and memory_data_size are 0; counters cleared. memory_enable drops immediately on reset_n low, even mid-transaction.
- States: IDLE, SELECT, READ_REQUEST, READ_RELEASE, WRITE_REQUEST, WRITE_RELEASE, FINISH.
- IDLE:
  - start=1 latches source, destination and remaining=length, and sets busy.
  - If length=0, go to FINISH with no bus activity. Otherwise go to SELECT.
- SELECT computes the chunk size:
  - word if ALLOW_WORD, source[1:0]=0, destination[1:0]=0 and remaining>=4;
  - else half if source[0]=0, destination[0]=0 and remaining>=2;
  - else byte.
  - Drive memory_address=source, memory_data_size=chunk size, memory_operation=0, memory_enable=1. Go to READ_REQUEST.
- READ_REQUEST: hold outputs stable. On the first cycle memory_ready=1, capture memory_data_in masked to the chunk size, clear memory_enable, and go to READ_RELEASE.
- READ_RELEASE:
  - Wait for memory_ready=0.
  - Then drive memory_address=destination, memory_operation=1, memory_data_out=captured data (upper bits zero), memory_enable=1. Go to WRITE_REQUEST.
  - memory_enable is never reasserted while memory_ready is still high.
- WRITE_REQUEST: hold outputs stable. On memory_ready=1, clear memory_enable and go to WRITE_RELEASE.
- WRITE_RELEASE:
  - On memory_ready=0, advance source and destination by the chunk bytes (1/2/4) and subtract the same from remaining.
  - Go to FINISH if remaining reaches 0, else SELECT.
- FINISH: done=1 for exactly one cycle, busy=0 in the same cycle, return to IDLE.
- Minimum latency per chunk, with ready answered in one cycle: 1 select + 2 read + 2 write = 5 cycles.
- Boundaries:
  - Address arithmetic wraps modulo 2^ADDRESS_WIDTH.
  - start while busy is ignored and latched inputs do not change.
  - memory_ready high in IDLE or SELECT is ignored.
  - Overlapping regions are copied strictly ascending with no overlap protection.
  - A responder that never asserts ready hangs the block in the REQUEST state. Only reset exits.

Decomposition:
- Shared package memory_bus_defs:
  - size constants MEMORY_SIZE_BYTE=0, MEMORY_SIZE_HALF=1, MEMORY_SIZE_WORD=2;
  - MEMORY_OPERATION_READ=0, MEMORY_OPERATION_WRITE=1;
  - the state encoding enum.
- One natural sub-module: memory_chunk_select. It is combinational and takes source, destination, remaining and ALLOW_WORD, and returns size and byte count. It is reusable by any future initiator, including the CPU load/store path.

Test Plan:
- Aligned copy: source=0x100, destination=0x200, length=8 -> two word reads at 0x100/0x104 and two word writes at 0x200/0x204. RAM 0x200..0x207 equals 0x100..0x107. done pulses once; busy is low afterwards.
- Misaligned copy: source=0x101, destination=0x301, length=5 -> access sizes in order byte, half, half (addresses 0x101, 0x102, 0x104). Write data upper bits are zero.
- Handshake stretching: the responder delays ready by 3 cycles and holds ready high 2 extra cycles after enable drops. Address, size and data must stay stable while enable is high, and enable must not reassert before ready falls.
- length=0 with start -> done on the second cycle after start. memory_enable stays 0 throughout.
- Reset mid-write: pulse reset_n low while in WRITE_REQUEST -> memory_enable is 0 within the same time step. Afterwards IDLE, busy=0, and a new start (source=0, destination=0x40, length=4) completes correctly.
- Wrap and ignored start: source=0xFFFFFFFE, length=4, ALLOW_WORD=1 -> half at 0xFFFFFFFE then half at 0x00000000. A second start pulsed mid-copy is ignored.
